// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: issues single-outstanding word fetches over a
// req/ack interface, buffers {pc, instr} pairs in a small FIFO and presents the
// head to the IF/ID register. A redirect from execute flushes the buffer and,
// if a request is still in flight, drains its response before refetching.
module fetch_prefetch_unit #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_f,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_f,
  output logic [31:0] pc_f,
  output logic [31:0] pc_plus4_f,
  output logic        instr_valid_f
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DRAIN
  } state_t;

  state_t          state;
  state_t          stateNext;

  logic [31:0]     fetchPc;
  logic [31:0]     drainAddr;
  logic [31:0]     pcMem    [DEPTH];
  logic [31:0]     instrMem [DEPTH];
  logic [AW-1:0]   rdPtr;
  logic [AW-1:0]   wrPtr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   countNext;

  logic            push;
  logic            pop;
  logic            hasSpace;

  // Handshake qualifiers and post-update occupancy used by the FSM.
  always_comb begin
    pop       = instr_valid_f & ~stall_f;
    push      = (state == WAIT) & imem_ack & ~redirect;
    countNext = count + CW'(push) - CW'(pop);
    hasSpace  = (countNext < CW'(DEPTH));
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // FSM next-state logic; a redirect decides whether a response is still owed.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (!redirect && hasSpace) begin
          stateNext = WAIT;
        end
      end
      WAIT: begin
        if (redirect) begin
          stateNext = imem_ack ? IDLE : DRAIN;
        end else if (imem_ack) begin
          stateNext = hasSpace ? WAIT : IDLE;
        end
      end
      DRAIN: begin
        if (imem_ack) begin
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // FSM outputs; while draining, the abandoned address is held on the bus.
  always_comb begin
    imem_req  = (state == WAIT) || (state == DRAIN);
    imem_addr = (state == DRAIN) ? drainAddr : fetchPc;
  end

  // Fetch address, FIFO pointers and occupancy; redirect overrides push and pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetchPc   <= RESET_PC;
      drainAddr <= RESET_PC;
      rdPtr     <= '0;
      wrPtr     <= '0;
      count     <= '0;
    end else if (redirect) begin
      fetchPc <= redirect_pc;
      count   <= '0;
      rdPtr   <= wrPtr;
      if ((state == WAIT) && !imem_ack) begin
        drainAddr <= fetchPc;
      end
    end else begin
      if (push) begin
        wrPtr   <= wrPtr + AW'(1);
        fetchPc <= fetchPc + 32'd4;
      end
      if (pop) begin
        rdPtr <= rdPtr + AW'(1);
      end
      count <= countNext;
    end
  end

  // FIFO storage; contents are only observed through count, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      pcMem[wrPtr]    <= fetchPc;
      instrMem[wrPtr] <= imem_rdata;
    end
  end

  // Fetch-stage outputs straight from the FIFO head (no ack bypass).
  always_comb begin
    instr_valid_f = (count != '0);
    instr_f       = instr_valid_f ? instrMem[rdPtr] : NOP_INSTR;
    pc_f          = instr_valid_f ? pcMem[rdPtr] : fetchPc;
    pc_plus4_f    = pc_f + 32'd4;
  end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Bench for fetch_prefetch_unit: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue-based model.
module tb_fetch_prefetch_unit;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_f;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr_f;
  logic [31:0] pc_f;
  logic [31:0] pc_plus4_f;
  logic        instr_valid_f;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  fetch_prefetch_unit #(
    .DEPTH(DEPTH),
    .RESET_PC(RESET_PC),
    .NOP_INSTR(NOP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stall_f(stall_f),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .instr_f(instr_f),
    .pc_f(pc_f),
    .pc_plus4_f(pc_plus4_f),
    .instr_valid_f(instr_valid_f)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        q[$];
  logic [31:0] mPc;
  logic [31:0] mStale;
  bit          mReq;
  bit          mDrop;

  task automatic modelReset();
    q.delete();
    mPc    = RESET_PC;
    mStale = RESET_PC;
    mReq   = 1'b0;
    mDrop  = 1'b0;
  endtask

  task automatic modelStep();
    bit doPop;
    doPop = (q.size() > 0) && !stall_f;
    if (redirect) begin
      q.delete();
      if (mReq && !imem_ack) begin
        if (!mDrop) mStale = mPc;
        mDrop = 1'b1;
      end else begin
        mReq  = 1'b0;
        mDrop = 1'b0;
      end
      mPc = redirect_pc;
    end else if (mReq && imem_ack) begin
      if (mDrop) begin
        mDrop = 1'b0;
        mReq  = 1'b0;
        if (doPop) void'(q.pop_front());
      end else begin
        if (doPop) void'(q.pop_front());
        q.push_back({mPc, imem_rdata});
        mPc  = mPc + 32'd4;
        mReq = (q.size() < DEPTH);
      end
    end else begin
      if (doPop) void'(q.pop_front());
      if (!mReq) mReq = (q.size() < DEPTH);
    end
  endtask

  initial begin
    modelReset();
    forever begin
      @(negedge rst);
      modelReset();
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      if (rst === 1'b1) modelStep();
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    logic [31:0] expPc;
    logic [31:0] expIns;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        expPc  = (q.size() > 0) ? q[0].pc  : mPc;
        expIns = (q.size() > 0) ? q[0].ins : NOP;
        check("model imem_req", 32'(imem_req), 32'(mReq));
        if (mReq) check("model imem_addr", imem_addr, mDrop ? mStale : mPc);
        check("model instr_valid_f", 32'(instr_valid_f), 32'(q.size() > 0));
        check("model instr_f", instr_f, expIns);
        check("model pc_f", pc_f, expPc);
        check("model pc_plus4_f", pc_plus4_f, expPc + 32'd4);
      end
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #400000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          acks;
    logic [31:0] prevPc;
    bit          seen;
    int          waitCnt;
    int          lat;
    int          stallPct;

    rst         = 1'b0;
    stall_f     = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_ack    = 1'b0;
    imem_rdata  = '0;
    #1;
    check("reset imem_req", 32'(imem_req), 32'd0);
    check("reset instr_f", instr_f, NOP);
    check("reset pc_f", pc_f, RESET_PC);
    check("reset valid", 32'(instr_valid_f), 32'd0);
    step();
    step();
    rst = 1'b1;

    // First fetch, ack latency 2.
    step();
    check("t1 req", 32'(imem_req), 32'd1);
    check("t1 addr", imem_addr, 32'h0);
    check("t1 nop before ack", instr_f, NOP);
    step();
    check("t1 nop while waiting", instr_f, NOP);
    imem_ack   = 1'b1;
    imem_rdata = 32'h0050_0093;
    step();
    check("t1 instr", instr_f, 32'h0050_0093);
    check("t1 pc", pc_f, 32'h0);
    check("t1 pc+4", pc_plus4_f, 32'h4);
    check("t1 valid", 32'(instr_valid_f), 32'd1);

    // Fill under stall with an ack every cycle.
    stall_f = 1'b1;
    acks    = 0;
    for (int i = 0; i < 10 && imem_req; i++) begin
      imem_ack   = 1'b1;
      imem_rdata = 32'h1000_0000 | imem_addr;
      acks++;
      step();
    end
    imem_ack = 1'b0;
    check("t2 extra acks", 32'(acks), 32'd3);
    check("t2 req off when full", 32'(imem_req), 32'd0);
    step();
    check("t2 req stays off", 32'(imem_req), 32'd0);
    check("t2 head pc", pc_f, 32'h0);
    stall_f = 1'b0;
    step();
    check("t2 head pc 4", pc_f, 32'h4);
    check("t2 head instr 4", instr_f, 32'h1000_0004);
    check("t2 resume req", 32'(imem_req), 32'd1);
    check("t2 resume addr", imem_addr, 32'h10);
    step();
    check("t2 head pc 8", pc_f, 32'h8);
    step();
    check("t2 head pc 12", pc_f, 32'hC);
    step();
    check("t2 empty", 32'(instr_valid_f), 32'd0);
    check("t2 empty pc", pc_f, 32'h10);

    // Redirect while waiting, no ack: drain the stale response.
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    check("t3 flushed", 32'(instr_valid_f), 32'd0);
    check("t3 pc_f", pc_f, 32'h100);
    check("t3 drain req", 32'(imem_req), 32'd1);
    check("t3 drain addr held", imem_addr, 32'h10);
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack = 1'b0;
    check("t3 idle after drain", 32'(imem_req), 32'd0);
    check("t3 no stale data", instr_f, NOP);
    step();
    check("t3 refetch req", 32'(imem_req), 32'd1);
    check("t3 refetch addr", imem_addr, 32'h100);
    check("t3 still empty", 32'(instr_valid_f), 32'd0);

    // Redirect coinciding with an ack.
    imem_ack    = 1'b1;
    imem_rdata  = 32'h1111_1111;
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    step();
    imem_ack = 1'b0;
    redirect = 1'b0;
    check("t4 no drain", 32'(imem_req), 32'd0);
    check("t4 empty", 32'(instr_valid_f), 32'd0);
    check("t4 pc_f", pc_f, 32'h200);
    step();
    check("t4 req", 32'(imem_req), 32'd1);
    check("t4 addr", imem_addr, 32'h200);

    // Steady stream with 1-cycle ack.
    seen = 1'b0;
    prevPc = '0;
    for (int i = 0; i < 12; i++) begin
      imem_ack   = imem_req;
      imem_rdata = 32'h2000_0000 | imem_addr;
      step();
      if (instr_valid_f) begin
        if (seen) check("t5 pc step", pc_f, prevPc + 32'd4);
        prevPc = pc_f;
        seen   = 1'b1;
      end
    end
    imem_ack = 1'b0;
    check("t5 saw stream", 32'(seen), 32'd1);
    step();

    // Async reset mid-request, with an ack arriving during reset.
    check("t6 pre req", 32'(imem_req), 32'd1);
    rst = 1'b0;
    #1;
    check("t6 async req", 32'(imem_req), 32'd0);
    check("t6 async valid", 32'(instr_valid_f), 32'd0);
    check("t6 async pc", pc_f, RESET_PC);
    check("t6 async instr", instr_f, NOP);
    imem_ack   = 1'b1;
    imem_rdata = 32'h0BAD_0BAD;
    step();
    step();
    imem_ack = 1'b0;
    rst = 1'b1;
    step();
    check("t6 req after reset", 32'(imem_req), 32'd1);
    check("t6 addr after reset", imem_addr, RESET_PC);
    check("t6 no push", 32'(instr_valid_f), 32'd0);

    // Randomized traffic.
    waitCnt  = 0;
    lat      = 1;
    stallPct = 30;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) stallPct = $urandom_range(0, 90);
      stall_f  = ($urandom_range(0, 99) < stallPct);
      redirect = ($urandom_range(0, 99) < 4);
      if ($urandom_range(0, 7) == 0) redirect_pc = 32'hFFFF_FFF0;
      else redirect_pc = $urandom & 32'hFFFF_FFFC;
      if (imem_req) begin
        if (waitCnt >= lat) begin
          imem_ack   = 1'b1;
          imem_rdata = $urandom;
          waitCnt    = 0;
          lat        = $urandom_range(0, 3);
        end else begin
          imem_ack = 1'b0;
          waitCnt++;
        end
      end else begin
        imem_ack   = ($urandom_range(0, 99) < 3);
        imem_rdata = $urandom;
        waitCnt    = 0;
      end
      step();
    end
    stall_f  = 1'b0;
    redirect = 1'b0;
    imem_ack = 1'b0;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
